// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word access from the core, drives
// a word-aligned memory request with a byte mask, and returns an extended
// load result or a trap.
//
// Handshake rule used on every channel: a transfer happens on the rising
// edge where valid and ready are both 1. The core-side request is offered
// with i_req_valid and taken while o_req_ready is high. The response is
// held (o_resp_valid, o_resp_rdata, o_resp_trap unchanged) until
// i_resp_ready. The memory request is held until i_mem_ready. Read data is
// taken on any WAIT cycle with i_mem_valid high.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   // core request
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_store,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_unsigned,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   // core response
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_trap,
   // memory side
   output logic [31:0] o_mem_addr,
   output logic        o_mem_ren,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_mask,
   input  logic        i_mem_ready,
   input  logic        i_mem_valid,
   input  logic [31:0] i_mem_rdata,
   // debug view of the control state
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   // The WAIT counter only needs to reach TIMEOUT-1: the cycle on which it
   // holds TIMEOUT-1 is the last one on which read data is still accepted.
   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t        state_q, state_d;
   logic          store_q, store_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          trap_q, trap_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          req_misaligned;
   logic [31:0]   load_shifted;
   logic [31:0]   load_ext;
   logic [3:0]    mask_raw;
   logic          in_req;
   logic          in_resp;

   // Alignment check on the incoming request, used on the accept edge.
   always_comb begin
      req_misaligned = 1'b0;
      case (i_req_size)
         SZ_BYTE: req_misaligned = 1'b0;
         SZ_HALF: req_misaligned = i_req_addr[0];
         SZ_WORD: req_misaligned = (i_req_addr[1:0] != 2'b00);
         default: req_misaligned = 1'b1;
      endcase
   end

   // Align the returned word to the requested byte lane and extend it.
   always_comb begin
      load_shifted = i_mem_rdata >> {addr_q[1:0], 3'b000};
      load_ext     = load_shifted;
      case (size_q)
         SZ_BYTE: load_ext = {{24{~uns_q & load_shifted[7]}}, load_shifted[7:0]};
         SZ_HALF: load_ext = {{16{~uns_q & load_shifted[15]}}, load_shifted[15:0]};
         default: load_ext = load_shifted;
      endcase
   end

   // Byte-enable pattern for the latched request.
   always_comb begin
      mask_raw = 4'b1111;
      case (size_q)
         SZ_BYTE: mask_raw = 4'b0001 << addr_q[1:0];
         SZ_HALF: mask_raw = 4'b0011 << {addr_q[1], 1'b0};
         default: mask_raw = 4'b1111;
      endcase
   end

   // Next-state and datapath update for the request/response sequence.
   always_comb begin
      state_d = state_q;
      store_d = store_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      trap_d  = trap_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (i_req_valid) begin
               store_d = i_req_store;
               size_d  = i_req_size;
               uns_d   = i_req_unsigned;
               addr_d  = i_req_addr;
               wdata_d = i_req_wdata;
               rdata_d = '0;
               trap_d  = 1'b0;
               cnt_d   = '0;
               if (req_misaligned) begin
                  // Misaligned accesses never reach memory.
                  trap_d  = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (i_mem_ready) begin
               cnt_d   = '0;
               state_d = store_q ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            // Data arriving on the final counted cycle still wins.
            if (i_mem_valid) begin
               rdata_d = load_ext;
               trap_d  = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               trap_d  = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RESP: begin
            if (i_resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any in-flight access.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         store_q <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         trap_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         store_q <= store_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         trap_q  <= trap_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_req  = (state_q == S_REQ);
   assign in_resp = (state_q == S_RESP);

   // Memory outputs are only live in REQ, so ren and wen can never overlap
   // and everything reads zero otherwise.
   assign o_mem_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
   assign o_mem_ren   = in_req & ~store_q;
   assign o_mem_wen   = in_req & store_q;
   assign o_mem_wdata = in_req ? (wdata_q << {addr_q[1:0], 3'b000}) : '0;
   assign o_mem_mask  = in_req ? mask_raw : 4'b0000;

   assign o_req_ready  = (state_q == S_IDLE);
   assign o_resp_valid = in_resp;
   assign o_resp_rdata = in_resp ? rdata_q : '0;
   assign o_resp_trap  = in_resp & trap_q;

   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, hand-written reset
// sequences, and randomized transactions checked against a rule-level model.
module tb_load_store_unit;

   localparam int DEF_TO = 255;
   localparam int T4_TO  = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   logic        req_valid, req_store, req_uns;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_ready, mem_ready, mem_valid;
   logic [31:0] mem_rdata;
   logic        use_t4;
   logic        junk_en;
   logic        a_req_valid, b_req_valid;

   assign a_req_valid = req_valid & ~use_t4;
   assign b_req_valid = req_valid & use_t4;

   // ---------------- DUT outputs ----------------
   logic        a_req_ready, a_resp_valid, a_resp_trap, a_mem_ren, a_mem_wen;
   logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
   logic [3:0]  a_mem_mask;
   logic [1:0]  a_dbg;
   logic        b_req_ready, b_resp_valid, b_resp_trap, b_mem_ren, b_mem_wen;
   logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
   logic [3:0]  b_mem_mask;
   logic [1:0]  b_dbg;

   load_store_unit #(.TIMEOUT(DEF_TO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
      .i_req_store(req_store), .i_req_size(req_size), .i_req_unsigned(req_uns),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_resp_valid(a_resp_valid), .i_resp_ready(resp_ready),
      .o_resp_rdata(a_resp_rdata), .o_resp_trap(a_resp_trap),
      .o_mem_addr(a_mem_addr), .o_mem_ren(a_mem_ren), .o_mem_wen(a_mem_wen),
      .o_mem_wdata(a_mem_wdata), .o_mem_mask(a_mem_mask),
      .i_mem_ready(mem_ready), .i_mem_valid(mem_valid), .i_mem_rdata(mem_rdata),
      .o_dbg_state(a_dbg)
   );

   load_store_unit #(.TIMEOUT(T4_TO)) dut_t4 (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
      .i_req_store(req_store), .i_req_size(req_size), .i_req_unsigned(req_uns),
      .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_resp_valid(b_resp_valid), .i_resp_ready(resp_ready),
      .o_resp_rdata(b_resp_rdata), .o_resp_trap(b_resp_trap),
      .o_mem_addr(b_mem_addr), .o_mem_ren(b_mem_ren), .o_mem_wen(b_mem_wen),
      .o_mem_wdata(b_mem_wdata), .o_mem_mask(b_mem_mask),
      .i_mem_ready(mem_ready), .i_mem_valid(mem_valid), .i_mem_rdata(mem_rdata),
      .o_dbg_state(b_dbg)
   );

   // Outputs of whichever instance the current transaction targets.
   logic        s_req_ready, s_resp_valid, s_resp_trap, s_mem_ren, s_mem_wen;
   logic [31:0] s_resp_rdata, s_mem_addr, s_mem_wdata;
   logic [3:0]  s_mem_mask;

   always_comb begin
      if (use_t4) begin
         s_req_ready = b_req_ready;   s_resp_valid = b_resp_valid;
         s_resp_trap = b_resp_trap;   s_resp_rdata = b_resp_rdata;
         s_mem_ren   = b_mem_ren;     s_mem_wen    = b_mem_wen;
         s_mem_addr  = b_mem_addr;    s_mem_wdata  = b_mem_wdata;
         s_mem_mask  = b_mem_mask;
      end else begin
         s_req_ready = a_req_ready;   s_resp_valid = a_resp_valid;
         s_resp_trap = a_resp_trap;   s_resp_rdata = a_resp_rdata;
         s_mem_ren   = a_mem_ren;     s_mem_wen    = a_mem_wen;
         s_mem_addr  = a_mem_addr;    s_mem_wdata  = a_mem_wdata;
         s_mem_mask  = a_mem_mask;
      end
   end

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // ---------------- vector record ----------------
   typedef struct {
      bit          t4;
      bit          store;
      logic [1:0]  size;
      bit          uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mem_word;
      int          req_cycles;   // cycles the memory request is held (ready on the last)
      int          valid_at;     // WAIT-cycle index carrying read data
      int          resp_delay;   // response cycles before i_resp_ready
      logic [31:0] exp_rdata;
      bit          exp_trap;
      int          exp_lat;      // cycles from accept cycle to first o_resp_valid
      logic [31:0] exp_maddr;
      logic [3:0]  exp_mask;
      logic [31:0] exp_mwdata;
   } vec_t;

   function automatic vec_t mk(bit t4, bit st, logic [1:0] sz, bit un,
                               logic [31:0] a, logic [31:0] wd, logic [31:0] mw,
                               int rc, int va, int rd,
                               logic [31:0] e_rd, bit e_tr, int e_lat,
                               logic [31:0] e_ma, logic [3:0] e_mk, logic [31:0] e_wd);
      vec_t v;
      v.t4 = t4; v.store = st; v.size = sz; v.uns = un;
      v.addr = a; v.wdata = wd; v.mem_word = mw;
      v.req_cycles = rc; v.valid_at = va; v.resp_delay = rd;
      v.exp_rdata = e_rd; v.exp_trap = e_tr; v.exp_lat = e_lat;
      v.exp_maddr = e_ma; v.exp_mask = e_mk; v.exp_mwdata = e_wd;
      return v;
   endfunction

   function automatic bit is_misaligned(logic [1:0] sz, logic [31:0] a);
      return (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) || (sz == 2'b10 && (a % 4) != 0);
   endfunction

   // Reference model: expected results from the access rules by arithmetic.
   function automatic vec_t model(vec_t vi);
      vec_t   v;
      int     to;
      int     k;
      longint w;
      v  = vi;
      to = v.t4 ? T4_TO : DEF_TO;
      k  = int'(v.addr % 4);
      v.exp_maddr  = v.addr - (v.addr % 4);
      v.exp_mask   = (v.size == 2'b00) ? 4'(1 << k) : (v.size == 2'b01) ? 4'(3 << k) : 4'hF;
      v.exp_mwdata = v.wdata << (8 * k);
      if (is_misaligned(v.size, v.addr)) begin
         v.exp_rdata = 0; v.exp_trap = 1; v.exp_lat = 1;
      end else if (v.store) begin
         v.exp_rdata = 0; v.exp_trap = 0; v.exp_lat = 1 + v.req_cycles;
      end else if (v.valid_at >= to) begin
         v.exp_rdata = 0; v.exp_trap = 1; v.exp_lat = 1 + v.req_cycles + to;
      end else begin
         v.exp_trap = 0;
         v.exp_lat  = 1 + v.req_cycles + v.valid_at + 1;
         w = longint'(v.mem_word) / (longint'(1) << (8 * k));
         if (v.size == 2'b00) begin
            w = w % 256;
            if (!v.uns && w >= 128) w = w - 256;
         end else if (v.size == 2'b01) begin
            w = w % 65536;
            if (!v.uns && w >= 32768) w = w - 65536;
         end
         v.exp_rdata = w[31:0];
      end
      return v;
   endfunction

   // ---------------- driver: one full transaction ----------------
   task automatic apply(input vec_t v, input string nm);
      int to, req_idx, wait_idx, last_wait, cyc, hold, resp_cyc;
      int ren_n, wen_n, both_n, mask_bad, mem_unstable, rsp_unstable, busy_ready;
      bit mis, got_resp, hs, done, m_seen;
      logic [31:0] r_rdata, m_addr, m_wdata;
      logic        r_trap, m_ren, m_wen, post_ready, post_valid;
      logic [3:0]  m_mask;
      req_idx = 0; wait_idx = 0; hold = 0; resp_cyc = 0;
      ren_n = 0; wen_n = 0; both_n = 0; mask_bad = 0; mem_unstable = 0;
      rsp_unstable = 0; busy_ready = 0;
      got_resp = 0; hs = 0; done = 0; m_seen = 0;
      r_rdata = '0; r_trap = 1'b0; m_addr = '0; m_wdata = '0; m_mask = '0;
      m_ren = 1'b0; m_wen = 1'b0; post_ready = 1'b0; post_valid = 1'b1;
      to        = v.t4 ? T4_TO : DEF_TO;
      mis       = is_misaligned(v.size, v.addr);
      last_wait = (v.valid_at < to) ? v.valid_at : to - 1;
      use_t4    = v.t4;
      req_store = v.store; req_size = v.size; req_uns = v.uns;
      req_addr  = v.addr;  req_wdata = v.wdata;
      req_valid = 1'b1;
      cyc = 0;
      while (s_req_ready !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({nm, ".req_ready"}, s_req_ready, 1);
      @(posedge clk); #1;
      // Keep a different request on the bus; it must not be taken early.
      req_store = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
      req_uns   = 1'($urandom_range(0, 1)); req_addr = $urandom; req_wdata = $urandom;
      cyc = 1;
      while (!done && cyc < 400) begin
         if (hs) begin
            post_ready = s_req_ready;
            post_valid = s_resp_valid;
            done = 1;
         end else begin
            if (s_req_ready) busy_ready++;
            if (s_mem_ren && s_mem_wen) both_n++;
            if (s_mem_ren) ren_n++;
            if (s_mem_wen) wen_n++;
            if (s_mem_ren || s_mem_wen) begin
               if (!m_seen) begin
                  m_seen = 1; m_addr = s_mem_addr; m_mask = s_mem_mask;
                  m_wdata = s_mem_wdata; m_ren = s_mem_ren; m_wen = s_mem_wen;
               end else if (m_addr !== s_mem_addr || m_mask !== s_mem_mask ||
                            m_wdata !== s_mem_wdata || m_ren !== s_mem_ren ||
                            m_wen !== s_mem_wen) begin
                  mem_unstable++;
               end
            end else if (s_mem_mask !== 4'b0000) begin
               mask_bad++;
            end
            if (s_resp_valid) begin
               if (!got_resp) begin
                  got_resp = 1; resp_cyc = cyc;
                  r_rdata = s_resp_rdata; r_trap = s_resp_trap;
               end else if (s_resp_rdata !== r_rdata || s_resp_trap !== r_trap) begin
                  rsp_unstable++;
               end
               if (hold >= v.resp_delay) begin
                  resp_ready = 1'b1; req_valid = 1'b0; hs = 1;
               end else begin
                  resp_ready = 1'b0;
               end
               hold++;
            end else begin
               resp_ready = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            // Memory model: scripted REQ/WAIT phases, noise elsewhere.
            mem_ready = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_valid = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
            if (!mis && req_idx < v.req_cycles) begin
               mem_ready = (req_idx == v.req_cycles - 1);
               req_idx++;
            end else if (!mis && !v.store && wait_idx <= last_wait) begin
               mem_valid = (wait_idx == v.valid_at);
               if (mem_valid) mem_rdata = v.mem_word;
               wait_idx++;
            end
         end
         if (!done) begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      req_valid = 1'b0; resp_ready = 1'b0; mem_ready = 1'b0; mem_valid = 1'b0;
      chk({nm, ".got_resp"}, got_resp, 1);
      chk({nm, ".latency"}, resp_cyc, v.exp_lat);
      chk({nm, ".rdata"}, r_rdata, v.exp_rdata);
      chk({nm, ".trap"}, r_trap, v.exp_trap);
      chk({nm, ".resp_stable"}, rsp_unstable, 0);
      chk({nm, ".idle_after"}, post_ready, 1);
      chk({nm, ".valid_dropped"}, post_valid, 0);
      chk({nm, ".busy_ready"}, busy_ready, 0);
      chk({nm, ".ren_wen_both"}, both_n, 0);
      chk({nm, ".ren_cycles"}, ren_n, (!mis && !v.store) ? v.req_cycles : 0);
      chk({nm, ".wen_cycles"}, wen_n, (!mis && v.store) ? v.req_cycles : 0);
      chk({nm, ".mask_idle"}, mask_bad, 0);
      chk({nm, ".mem_stable"}, mem_unstable, 0);
      if (m_seen) begin
         chk({nm, ".mem_addr"}, m_addr, v.exp_maddr);
         chk({nm, ".mem_mask"}, m_mask, v.exp_mask);
         if (v.store) chk({nm, ".mem_wdata"}, m_wdata, v.exp_mwdata);
      end
   endtask

   // Reset while the unit waits for read data.
   task automatic rst_in_wait();
      int seen;
      use_t4 = 1'b0; junk_en = 1'b0;
      req_store = 1'b0; req_size = 2'b10; req_uns = 1'b0;
      req_addr = 32'h0000_E000; req_wdata = '0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rw.ren_in_req", s_mem_ren, 1);
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      chk("rw.ren_in_wait", s_mem_ren, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rw.req_ready", s_req_ready, 1);
      chk("rw.resp_valid", s_resp_valid, 0);
      chk("rw.ren", s_mem_ren, 0);
      chk("rw.wen", s_mem_wen, 0);
      mem_valid = 1'b1; mem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      mem_valid = 1'b0;
      seen = 0;
      repeat (6) begin
         if (s_resp_valid) seen++;
         @(posedge clk); #1;
      end
      chk("rw.no_resp", seen, 0);
      chk("rw.still_idle", s_req_ready, 1);
   endtask

   // ---------------- main sequence ----------------
   vec_t tbl[16];

   initial begin
      int seen;
      vec_t v;
      // directed table: lb, sh, misaligned lw/lh, lhu with slow data, etc.
      tbl[0]  = mk(0, 0, 2'b00, 0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1, 0, 0,
                   32'hFFFF_FF80, 0, 3, 32'h0000_1000, 4'b1000, 32'h0);
      tbl[1]  = mk(0, 1, 2'b01, 0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 4, 0, 0,
                   32'h0, 0, 5, 32'h0000_2000, 4'b1100, 32'hABCD_0000);
      tbl[2]  = mk(0, 0, 2'b10, 0, 32'h0000_3001, 32'h0, 32'h0, 1, 0, 0,
                   32'h0, 1, 1, 32'h0, 4'b0000, 32'h0);
      tbl[3]  = mk(0, 0, 2'b01, 0, 32'h0000_3003, 32'h0, 32'h0, 1, 0, 0,
                   32'h0, 1, 1, 32'h0, 4'b0000, 32'h0);
      tbl[4]  = mk(0, 0, 2'b01, 1, 32'h0000_4002, 32'h0, 32'h8001_0000, 1, 10, 3,
                   32'h0000_8001, 0, 13, 32'h0000_4000, 4'b1100, 32'h0);
      tbl[5]  = mk(0, 1, 2'b10, 0, 32'h0000_5000, 32'hDEAD_BEEF, 32'h0, 1, 0, 2,
                   32'h0, 0, 2, 32'h0000_5000, 4'b1111, 32'hDEAD_BEEF);
      tbl[6]  = mk(0, 0, 2'b01, 0, 32'h0000_6000, 32'h0, 32'h1234_8765, 1, 0, 0,
                   32'hFFFF_8765, 0, 3, 32'h0000_6000, 4'b0011, 32'h0);
      tbl[7]  = mk(0, 0, 2'b00, 1, 32'h0000_7001, 32'h0, 32'hAABB_CCDD, 1, 1, 0,
                   32'h0000_00CC, 0, 4, 32'h0000_7000, 4'b0010, 32'h0);
      tbl[8]  = mk(0, 1, 2'b00, 0, 32'h0000_8002, 32'h1234_5678, 32'h0, 2, 0, 1,
                   32'h0, 0, 3, 32'h0000_8000, 4'b0100, 32'h5678_0000);
      tbl[9]  = mk(0, 0, 2'b11, 0, 32'h0000_9000, 32'h0, 32'h0, 1, 0, 0,
                   32'h0, 1, 1, 32'h0, 4'b0000, 32'h0);
      tbl[10] = mk(0, 0, 2'b10, 0, 32'h0000_A000, 32'h0, 32'h0123_4567, 3, 2, 1,
                   32'h0123_4567, 0, 7, 32'h0000_A000, 4'b1111, 32'h0);
      tbl[11] = mk(0, 0, 2'b00, 0, 32'h0000_B000, 32'h0, 32'h0000_007F, 1, 0, 0,
                   32'h0000_007F, 0, 3, 32'h0000_B000, 4'b0001, 32'h0);
      tbl[12] = mk(1, 0, 2'b10, 0, 32'h0000_C000, 32'h0, 32'hCAFE_F00D, 1, 100, 0,
                   32'h0, 1, 6, 32'h0000_C000, 4'b1111, 32'h0);
      tbl[13] = mk(1, 0, 2'b10, 0, 32'h0000_C004, 32'h0, 32'hCAFE_F00D, 1, 3, 0,
                   32'hCAFE_F00D, 0, 6, 32'h0000_C004, 4'b1111, 32'h0);
      tbl[14] = mk(1, 0, 2'b00, 0, 32'h0000_C005, 32'h0, 32'h0000_AA00, 1, 4, 0,
                   32'h0, 1, 6, 32'h0000_C004, 4'b0010, 32'h0);
      tbl[15] = mk(0, 1, 2'b01, 0, 32'h0000_D001, 32'h0000_1111, 32'h0, 1, 0, 0,
                   32'h0, 1, 1, 32'h0, 4'b0000, 32'h0);

      // reset with a (misaligned) request already offered; it must be dropped
      rst = 1'b1; use_t4 = 1'b0; junk_en = 1'b0;
      req_valid = 1'b1; req_store = 1'b0; req_size = 2'b11; req_uns = 1'b0;
      req_addr = 32'h0000_0001; req_wdata = '0;
      resp_ready = 1'b0; mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; req_valid = 1'b0;
      chk("rst.req_ready", s_req_ready, 1);
      chk("rst.resp_valid", s_resp_valid, 0);
      chk("rst.resp_rdata", s_resp_rdata, 0);
      chk("rst.resp_trap", s_resp_trap, 0);
      chk("rst.mem_ren", s_mem_ren, 0);
      chk("rst.mem_wen", s_mem_wen, 0);
      chk("rst.mem_mask", s_mem_mask, 0);
      chk("rst.mem_addr", s_mem_addr, 0);
      chk("rst.mem_wdata", s_mem_wdata, 0);
      chk("rst.t4_req_ready", b_req_ready, 1);
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (s_resp_valid) seen++;
      end
      chk("rst.req_dropped", seen, 0);

      for (int i = 0; i < 16; i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      rst_in_wait();

      junk_en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         v.t4         = ($urandom_range(0, 3) == 0);
         v.store      = 1'($urandom_range(0, 1));
         v.size       = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         v.uns        = 1'($urandom_range(0, 1));
         v.addr       = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            // bias toward naturally aligned addresses
            if (v.size == 2'b01) v.addr[0] = 1'b0;
            if (v.size == 2'b10) v.addr[1:0] = 2'b00;
         end
         v.wdata      = $urandom;
         v.mem_word   = $urandom;
         v.req_cycles = $urandom_range(1, 4);
         v.valid_at   = $urandom_range(0, 6);
         v.resp_delay = $urandom_range(0, 3);
         v = model(v);
         apply(v, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
